afifo_wr_ctrl: RTL and testbench

Write-side pointer and flag controller for the dual-clock FIFOs in the common library. It runs entirely in the write domain and owns the write pointer, built on the gray-code counter. It synchronizes the read domain's gray pointer and produces write enable/address for the storage RAM, full/almost-full flags, fill level and a sticky overflow error. A mirrored read-side controller and a dual-port RAM complete the FIFO.

---
 rtl/afifo_pkg.sv | 24 ++
 rtl/gry_cntr.sv | 42 ++++
 rtl/afifo_wr_ctrl.sv | 101 ++++++++++
 tb/tb_afifo_wr_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// Shared definitions for the dual-clock FIFO controllers (write and read side).
package afifo_pkg;

    // Library default address width and the matching FIFO depth.
    localparam int PTR_W_DEF = 4;
    localparam int DEPTH     = 2 ** PTR_W_DEF;

    // Gray to binary: each binary bit is the XOR of all gray bits at and above it.
    // Operates on 32 bits; callers zero-extend narrower pointers and truncate the result.
    function automatic logic [31:0] gray2bin(input logic [31:0] gry);
        logic [31:0] bin;
        bin[31] = gry[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gry[i];
        end
        return bin;
    endfunction

    // Binary to gray: adjacent values differ in exactly one bit.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gry_cntr.sv
// Gray-code counter: binary state register with a registered gray copy, so the
// gray output comes straight from flops and exposes its next value for look-ahead.
module gry_cntr
    import afifo_pkg::*;
#(
    parameter int               WIDTH   = 5,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] gry_cnt,
    output logic [WIDTH-1:0] gry_cnt_nxt
);

    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gry_reg;

    // Next count: advance by one on enable, wrapping naturally at 2^WIDTH.
    always_comb begin
        bin_next    = bin_reg;
        if (en) begin
            bin_next = bin_reg + WIDTH'(1);
        end
        gry_cnt_nxt = WIDTH'(bin2gray(32'(bin_next)));
    end

    // Count registers; the gray copy is registered so consumers see a glitch-free value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg <= RST_VAL;
            gry_reg <= WIDTH'(bin2gray(32'(RST_VAL)));
        end else begin
            bin_reg <= bin_next;
            gry_reg <= gry_cnt_nxt;
        end
    end

    assign gry_cnt = gry_reg;

endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO: owns the gray write pointer,
// synchronizes the read pointer and produces RAM write strobe/address and flags.
module afifo_wr_ctrl
    import afifo_pkg::*;
#(
    parameter int PTR_W        = PTR_W_DEF,
    parameter int AFULL_THRESH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_req,
    input  logic [PTR_W:0]   rd_gry_ptr_async,
    input  logic             clr_err,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_addr,
    output logic [PTR_W:0]   wr_gry_ptr,
    output logic             full,
    output logic             afull,
    output logic [PTR_W:0]   fill_lvl,
    output logic             ovfl_err
);

    localparam logic [PTR_W:0] FIFO_DEPTH = (PTR_W+1)'(1 << PTR_W);
    localparam logic [PTR_W:0] AFULL_LVL  = (PTR_W+1)'(AFULL_THRESH);

    logic [PTR_W:0] gry_cnt;
    logic [PTR_W:0] gry_cnt_nxt;
    logic [PTR_W:0] rd_sync1_reg;
    logic [PTR_W:0] rd_sync2_reg;
    logic [PTR_W:0] rd_bin_s;
    logic [PTR_W:0] wr_bin_nxt;
    logic [PTR_W:0] fill_next;
    logic           full_next;
    logic           afull_next;
    logic [PTR_W:0] fill_reg;
    logic           full_reg;
    logic           afull_reg;
    logic           ovfl_reg;

    // Writes are refused while full; gating with rst_n keeps the RAM quiet during reset.
    assign wr_en = wr_req & ~full_reg & rst_n;

    gry_cntr #(
        .WIDTH   (PTR_W + 1),
        .RST_VAL ('0)
    ) u_gry_cntr (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (wr_en),
        .gry_cnt     (gry_cnt),
        .gry_cnt_nxt (gry_cnt_nxt)
    );

    assign wr_gry_ptr = gry_cnt;
    assign wr_addr    = PTR_W'(gray2bin(32'(gry_cnt)));

    // Two-flop synchronizer; gray coding means at most one bit is in flight per update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sync1_reg <= '0;
            rd_sync2_reg <= '0;
        end else begin
            rd_sync1_reg <= rd_gry_ptr_async;
            rd_sync2_reg <= rd_sync1_reg;
        end
    end

    // Occupancy from the next write pointer, so flags line up with wr_gry_ptr each cycle.
    always_comb begin
        rd_bin_s   = (PTR_W+1)'(gray2bin(32'(rd_sync2_reg)));
        wr_bin_nxt = (PTR_W+1)'(gray2bin(32'(gry_cnt_nxt)));
        fill_next  = wr_bin_nxt - rd_bin_s;
        full_next  = (fill_next == FIFO_DEPTH);
        afull_next = (fill_next >= AFULL_LVL);
    end

    // Flag registers; sticky overflow where a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_reg  <= '0;
            full_reg  <= 1'b0;
            afull_reg <= 1'b0;
            ovfl_reg  <= 1'b0;
        end else begin
            fill_reg  <= fill_next;
            full_reg  <= full_next;
            afull_reg <= afull_next;
            if (wr_req && full_reg) begin
                ovfl_reg <= 1'b1;
            end else if (clr_err) begin
                ovfl_reg <= 1'b0;
            end
        end
    end

    assign fill_lvl = fill_reg;
    assign full     = full_reg;
    assign afull    = afull_reg;
    assign ovfl_err = ovfl_reg;

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Bench for afifo_wr_ctrl (PTR_W=4, AFULL_THRESH=12): vector table with a
// scoreboard queue, plus streaming-wrap and asynchronous-reset sequences.
module tb_afifo_wr_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_req;
    logic [4:0] rd_gry_ptr_async;
    logic       clr_err;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_gry_ptr;
    logic       full;
    logic       afull;
    logic [4:0] fill_lvl;
    logic       ovfl_err;

    afifo_wr_ctrl #(
        .PTR_W        (4),
        .AFULL_THRESH (12)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_req           (wr_req),
        .rd_gry_ptr_async (rd_gry_ptr_async),
        .clr_err          (clr_err),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_gry_ptr       (wr_gry_ptr),
        .full             (full),
        .afull            (afull),
        .fill_lvl         (fill_lvl),
        .ovfl_err         (ovfl_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr_req;
        logic [4:0] rd_gry;
        logic       clr;
        logic       exp_wr_en;
        logic [4:0] exp_fill;
        logic       exp_full;
        logic       exp_afull;
        logic [4:0] exp_gry;
        logic [3:0] exp_addr;
        logic       exp_ovfl;
    } vec_t;

    typedef struct {
        logic [4:0] fill;
        logic       full;
        logic       afull;
        logic [4:0] gry;
        logic [3:0] addr;
        logic       ovfl;
    } out_t;

    localparam int NVEC = 27;

    vec_t vecs[NVEC];
    out_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference gray encoding of a write count (pointer space is 5 bits).
    function automatic logic [4:0] gray_of(input int cnt);
        int b;
        b = cnt % 32;
        return 5'(b ^ (b >> 1));
    endfunction

    function automatic vec_t mk(input logic req, input logic [4:0] rd, input logic clr,
                                input logic we, input logic [4:0] fill, input logic fl,
                                input logic af, input int wptr, input logic ov);
        vec_t v;
        v.wr_req    = req;
        v.rd_gry    = rd;
        v.clr       = clr;
        v.exp_wr_en = we;
        v.exp_fill  = fill;
        v.exp_full  = fl;
        v.exp_afull = af;
        v.exp_gry   = gray_of(wptr);
        v.exp_addr  = 4'(wptr % 16);
        v.exp_ovfl  = ov;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},    32'(wr_en),      32'd0);
        check({tag, "_gry"},      32'(wr_gry_ptr), 32'd0);
        check({tag, "_addr"},     32'(wr_addr),    32'd0);
        check({tag, "_full"},     32'(full),       32'd0);
        check({tag, "_afull"},    32'(afull),      32'd0);
        check({tag, "_fill"},     32'(fill_lvl),   32'd0);
        check({tag, "_ovfl"},     32'(ovfl_err),   32'd0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        out_t       e;
        logic [4:0] prev_gry;
        logic [4:0] hist[$];
        logic       saw_roll;

        // 16 writes with read pointer parked at 0.
        for (int i = 0; i < 16; i++) begin
            vecs[i] = mk(1'b1, 5'd0, 1'b0, 1'b1, 5'(i + 1), (i == 15), ((i + 1) >= 12), i + 1, 1'b0);
        end
        // Write while full: dropped, overflow set.
        vecs[16] = mk(1'b1, 5'd0,      1'b0, 1'b0, 5'd16, 1'b1, 1'b1, 16, 1'b1);
        // Overflow and clear together: overflow wins.
        vecs[17] = mk(1'b1, 5'd0,      1'b1, 1'b0, 5'd16, 1'b1, 1'b1, 16, 1'b1);
        // Clear alone.
        vecs[18] = mk(1'b0, 5'd0,      1'b1, 1'b0, 5'd16, 1'b1, 1'b1, 16, 1'b0);
        // Read pointer jumps to 4: visible on the third edge.
        vecs[19] = mk(1'b0, 5'b00110,  1'b0, 1'b0, 5'd16, 1'b1, 1'b1, 16, 1'b0);
        vecs[20] = mk(1'b0, 5'b00110,  1'b0, 1'b0, 5'd16, 1'b1, 1'b1, 16, 1'b0);
        vecs[21] = mk(1'b0, 5'b00110,  1'b0, 1'b0, 5'd12, 1'b0, 1'b1, 16, 1'b0);
        // Read pointer to 5: fill 11, afull drops.
        vecs[22] = mk(1'b0, 5'b00111,  1'b0, 1'b0, 5'd12, 1'b0, 1'b1, 16, 1'b0);
        vecs[23] = mk(1'b0, 5'b00111,  1'b0, 1'b0, 5'd12, 1'b0, 1'b1, 16, 1'b0);
        vecs[24] = mk(1'b0, 5'b00111,  1'b0, 1'b0, 5'd11, 1'b0, 1'b0, 16, 1'b0);
        // Writes resume: 11 -> 12 sets afull on the same edge.
        vecs[25] = mk(1'b1, 5'b00111,  1'b0, 1'b1, 5'd12, 1'b0, 1'b1, 17, 1'b0);
        vecs[26] = mk(1'b1, 5'b00111,  1'b0, 1'b1, 5'd13, 1'b0, 1'b1, 18, 1'b0);

        // Reset with a pending request: everything, including wr_en, stays 0.
        rst_n = 1'b0;
        wr_req = 1'b1;
        rd_gry_ptr_async = 5'd0;
        clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        $display("reset: outputs sampled with rst_n=0");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("wr_en_after_release", 32'(wr_en), 32'd1);

        // Table-driven phase.
        for (int i = 0; i < NVEC; i++) begin
            wr_req           = vecs[i].wr_req;
            rd_gry_ptr_async = vecs[i].rd_gry;
            clr_err          = vecs[i].clr;
            #1;
            check($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].exp_wr_en));
            e.fill  = vecs[i].exp_fill;
            e.full  = vecs[i].exp_full;
            e.afull = vecs[i].exp_afull;
            e.gry   = vecs[i].exp_gry;
            e.addr  = vecs[i].exp_addr;
            e.ovfl  = vecs[i].exp_ovfl;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check($sformatf("v%0d_scoreboard_empty", i), 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("v%0d_fill", i),  32'(fill_lvl),   32'(e.fill));
                check($sformatf("v%0d_full", i),  32'(full),       32'(e.full));
                check($sformatf("v%0d_afull", i), 32'(afull),      32'(e.afull));
                check($sformatf("v%0d_gry", i),   32'(wr_gry_ptr), 32'(e.gry));
                check($sformatf("v%0d_addr", i),  32'(wr_addr),    32'(e.addr));
                check($sformatf("v%0d_ovfl", i),  32'(ovfl_err),   32'(e.ovfl));
            end
            $display("vec %0d: wr_req=%0b rd_gry=%05b clr=%0b -> gry=%05b addr=%0d fill=%0d full=%0b afull=%0b ovfl=%0b",
                     i, vecs[i].wr_req, vecs[i].rd_gry, vecs[i].clr, wr_gry_ptr, wr_addr,
                     fill_lvl, full, afull, ovfl_err);
        end

        // Streaming wrap: read pointer follows the write pointer with a 3-cycle lag.
        rst_n = 1'b0;
        wr_req = 1'b0;
        clr_err = 1'b0;
        rd_gry_ptr_async = 5'd0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        wr_req = 1'b1;
        prev_gry = 5'd0;
        saw_roll = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            check($sformatf("s%0d_wr_en", k), 32'(wr_en), 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("s%0d_gry", k),      32'(wr_gry_ptr), 32'(gray_of(k + 1)));
            check($sformatf("s%0d_onebit", k),   32'($countones(prev_gry ^ wr_gry_ptr)), 32'd1);
            check($sformatf("s%0d_addr", k),     32'(wr_addr), 32'((k + 1) % 16));
            check($sformatf("s%0d_full", k),     32'(full), 32'd0);
            if (prev_gry == 5'b10000 && wr_gry_ptr == 5'b00000) begin
                saw_roll = 1'b1;
            end
            $display("stream %0d: gry=%05b addr=%0d fill=%0d full=%0b", k, wr_gry_ptr, wr_addr, fill_lvl, full);
            prev_gry = wr_gry_ptr;
            hist.push_back(wr_gry_ptr);
            if (hist.size() > 3) begin
                rd_gry_ptr_async = hist.pop_front();
            end
        end
        check("stream_rollover_seen", 32'(saw_roll), 32'd1);

        // Asynchronous reset in the middle of the burst.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        $display("midreset: outputs sampled %0t after rst_n fell", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
